// File: rtl/event_seq_pkg.sv
// Shared types and constants for the ordered-event sequencer.
package event_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    DONE,
    ERR
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_ORDER = 2'b01;
  localparam logic [1:0] ERR_TMO   = 2'b10;

endpackage

// File: rtl/edge_rise_det.sv
// Rising-edge detector: registers the inputs and flags 0->1 transitions.
module edge_rise_det #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] ev,
  output logic [W-1:0] rise
);

  logic [W-1:0] ev_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ev_q <= '0;
    else       ev_q <= ev;
  end

  assign rise = ev & ~ev_q;

endmodule

// File: rtl/event_seq_fsm.sv
// Ordered-event sequencer: accepts rising edges of ev[0..N_EV-1] in order,
// each within TMO_CYC cycles of the previous, reporting progress and errors.
module event_seq_fsm
  import event_seq_pkg::*;
#(
  parameter int unsigned N_EV    = 4,
  parameter int unsigned TMO_W   = 8,
  parameter int unsigned TMO_CYC = 200,
  parameter int unsigned STRICT  = 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    en,
  input  logic                    clr,
  input  logic [N_EV-1:0]         ev,
  output logic [$clog2(N_EV):0]   step,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [1:0]              err_code
);

  localparam int unsigned SW = $clog2(N_EV) + 1;

  state_t           state_q, state_d;
  logic [SW-1:0]    step_d;
  logic [TMO_W-1:0] timer_q, timer_d;
  logic [1:0]       code_d;
  logic [N_EV-1:0]  rise;
  logic [N_EV-1:0]  exp_mask;
  logic [N_EV-1:0]  others;
  logic             accept;

  edge_rise_det #(.W(N_EV)) u_edge (
    .clk  (clk),
    .rstn (rstn),
    .ev   (ev),
    .rise (rise)
  );

  // One-hot of the expected index; any other rise (including re-rise of an
  // already accepted bit) is out-of-order.
  always_comb begin
    exp_mask = '0;
    for (int unsigned i = 0; i < N_EV; i++) begin
      exp_mask[i] = (step == SW'(i));
    end
  end

  assign others = rise & ~exp_mask;
  assign accept = |(rise & exp_mask);

  always_comb begin
    state_d = state_q;
    step_d  = step;
    timer_d = timer_q;
    code_d  = err_code;
    case (state_q)
      IDLE: begin
        step_d  = '0;
        timer_d = '0;
        if (en && rise[0]) begin
          if ((STRICT != 0) && (|rise[N_EV-1:1])) begin
            state_d = ERR;
            code_d  = ERR_ORDER;
          end else begin
            state_d = ARMED;
            step_d  = SW'(1);
          end
        end
      end
      ARMED: begin
        if (!en) begin
          state_d = IDLE;
          step_d  = '0;
          timer_d = '0;
        end else if ((STRICT != 0) && (|others)) begin
          state_d = ERR;
          code_d  = ERR_ORDER;
        end else if (accept) begin
          step_d  = step + SW'(1);
          timer_d = '0;
          if (step == SW'(N_EV - 1)) state_d = DONE;
        end else if (timer_q == TMO_W'(TMO_CYC - 1)) begin
          state_d = ERR;
          code_d  = ERR_TMO;
        end else if (timer_q != '1) begin
          timer_d = timer_q + TMO_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        step_d  = '0;
        timer_d = '0;
      end
      ERR: begin
        if (clr) begin
          state_d = IDLE;
          step_d  = '0;
          timer_d = '0;
          code_d  = ERR_NONE;
        end
      end
      default: begin
        state_d = IDLE;
        step_d  = '0;
        timer_d = '0;
        code_d  = ERR_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      step     <= '0;
      timer_q  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      state_q  <= state_d;
      step     <= step_d;
      timer_q  <= timer_d;
      busy     <= (state_d == ARMED);
      done     <= (state_d == DONE);
      err      <= (state_d == ERR);
      err_code <= code_d;
    end
  end

endmodule

// File: tb/tb_event_seq_fsm.sv
// Directed bench: three sequencer configurations share stimulus
// (A strict/200, B lenient/200, C strict/10).
module tb_event_seq_fsm;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] ev = '0;

  logic [2:0] a_step, b_step, c_step;
  logic       a_busy, b_busy, c_busy, a_done, b_done, c_done, a_err, b_err, c_err;
  logic [1:0] a_code, b_code, c_code;
  logic [7:0] st_a, st_b, st_c, exp;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  event_seq_fsm #(.N_EV(4), .TMO_W(8), .TMO_CYC(200), .STRICT(1)) dut_a (
    .clk(clk), .rstn(rstn), .en(en), .clr(clr), .ev(ev),
    .step(a_step), .busy(a_busy), .done(a_done), .err(a_err), .err_code(a_code));

  event_seq_fsm #(.N_EV(4), .TMO_W(8), .TMO_CYC(200), .STRICT(0)) dut_b (
    .clk(clk), .rstn(rstn), .en(en), .clr(clr), .ev(ev),
    .step(b_step), .busy(b_busy), .done(b_done), .err(b_err), .err_code(b_code));

  event_seq_fsm #(.N_EV(4), .TMO_W(8), .TMO_CYC(10), .STRICT(1)) dut_c (
    .clk(clk), .rstn(rstn), .en(en), .clr(clr), .ev(ev),
    .step(c_step), .busy(c_busy), .done(c_done), .err(c_err), .err_code(c_code));

  assign st_a = {a_step, a_busy, a_done, a_err, a_code};
  assign st_b = {b_step, b_busy, b_done, b_err, b_code};
  assign st_c = {c_step, c_busy, c_done, c_err, c_code};

  // Packs {step, busy, done, err, err_code}
  function automatic logic [7:0] mk(input int s, input bit b, input bit d,
                                    input bit e, input int c);
    logic [2:0] s3;
    logic [1:0] c2;
    s3 = 3'(s);
    c2 = 2'(c);
    return {s3, b, d, e, c2};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    exp = mk(0, 0, 0, 0, 0);
    total_cnt++;
    if (st_a !== exp) $display("FAIL reset_async got %h exp %h", st_a, exp);
    else pass_cnt++;
    tick();
    tick();
    total_cnt++;
    if (st_c !== exp) $display("FAIL reset_held got %h exp %h", st_c, exp);
    else pass_cnt++;
    rstn = 1'b1;
    en = 1'b1;
    tick();
  endtask

  task automatic test_in_order();
    ev = 4'b0001; tick();
    exp = mk(1, 1, 0, 0, 0);
    total_cnt++;
    if (st_a !== exp) $display("FAIL inorder_s1 got %h exp %h", st_a, exp);
    else pass_cnt++;
    ev = 4'b0000; tick(); tick();
    total_cnt++;
    if (st_a !== exp) $display("FAIL inorder_hold1 got %h exp %h", st_a, exp);
    else pass_cnt++;
    ev = 4'b0010; tick();
    exp = mk(2, 1, 0, 0, 0);
    total_cnt++;
    if (st_a !== exp) $display("FAIL inorder_s2 got %h exp %h", st_a, exp);
    else pass_cnt++;
    ev = 4'b0000; tick(); tick();
    ev = 4'b0100; tick();
    exp = mk(3, 1, 0, 0, 0);
    total_cnt++;
    if (st_a !== exp) $display("FAIL inorder_s3 got %h exp %h", st_a, exp);
    else pass_cnt++;
    ev = 4'b0000; tick(); tick();
    ev = 4'b1000; tick();
    exp = mk(4, 0, 1, 0, 0);
    total_cnt++;
    if (st_a !== exp) $display("FAIL inorder_done got %h exp %h", st_a, exp);
    else pass_cnt++;
    total_cnt++;
    if (st_c !== exp) $display("FAIL inorder_done_c got %h exp %h", st_c, exp);
    else pass_cnt++;
    ev = 4'b0000; tick();
    exp = mk(0, 0, 0, 0, 0);
    total_cnt++;
    if (st_a !== exp) $display("FAIL inorder_idle got %h exp %h", st_a, exp);
    else pass_cnt++;
  endtask

  task automatic test_order_strict();
    ev = 4'b0001; tick();
    ev = 4'b0000; tick();
    ev = 4'b0100; tick();
    exp = mk(1, 0, 0, 1, 1);
    total_cnt++;
    if (st_a !== exp) $display("FAIL strict_err got %h exp %h", st_a, exp);
    else pass_cnt++;
    exp = mk(1, 1, 0, 0, 0);
    total_cnt++;
    if (st_b !== exp) $display("FAIL lenient_ignore got %h exp %h", st_b, exp);
    else pass_cnt++;
    ev = 4'b0000; en = 1'b0; tick();
    exp = mk(1, 0, 0, 1, 1);
    total_cnt++;
    if (st_a !== exp) $display("FAIL err_sticky_en0 got %h exp %h", st_a, exp);
    else pass_cnt++;
    exp = mk(0, 0, 0, 0, 0);
    total_cnt++;
    if (st_b !== exp) $display("FAIL abort_b got %h exp %h", st_b, exp);
    else pass_cnt++;
    clr = 1'b1; tick();
    total_cnt++;
    if (st_a !== exp) $display("FAIL clr_err got %h exp %h", st_a, exp);
    else pass_cnt++;
    clr = 1'b0; en = 1'b1; tick();
  endtask

  task automatic test_order_lenient();
    ev = 4'b0001; tick();
    ev = 4'b0000; tick();
    ev = 4'b0100; tick();
    exp = mk(1, 1, 0, 0, 0);
    total_cnt++;
    if (st_b !== exp) $display("FAIL lenient_skip got %h exp %h", st_b, exp);
    else pass_cnt++;
    ev = 4'b0000; tick();
    ev = 4'b0010; tick();
    exp = mk(2, 1, 0, 0, 0);
    total_cnt++;
    if (st_b !== exp) $display("FAIL lenient_s2 got %h exp %h", st_b, exp);
    else pass_cnt++;
    ev = 4'b0000; tick();
    ev = 4'b0100; tick();
    exp = mk(3, 1, 0, 0, 0);
    total_cnt++;
    if (st_b !== exp) $display("FAIL lenient_s3 got %h exp %h", st_b, exp);
    else pass_cnt++;
    ev = 4'b0000; tick();
    ev = 4'b1000; tick();
    exp = mk(4, 0, 1, 0, 0);
    total_cnt++;
    if (st_b !== exp) $display("FAIL lenient_done got %h exp %h", st_b, exp);
    else pass_cnt++;
    ev = 4'b0000; clr = 1'b1; tick();
    exp = mk(0, 0, 0, 0, 0);
    total_cnt++;
    if (st_b !== exp) $display("FAIL lenient_idle got %h exp %h", st_b, exp);
    else pass_cnt++;
    total_cnt++;
    if (st_a !== exp) $display("FAIL lenient_clr_a got %h exp %h", st_a, exp);
    else pass_cnt++;
    clr = 1'b0; tick();
  endtask

  task automatic test_timeout();
    ev = 4'b0001; tick();
    exp = mk(1, 1, 0, 0, 0);
    total_cnt++;
    if (st_c !== exp) $display("FAIL tmo_accept got %h exp %h", st_c, exp);
    else pass_cnt++;
    ev = 4'b0000;
    repeat (9) tick();
    total_cnt++;
    if (st_c !== exp) $display("FAIL tmo_early got %h exp %h", st_c, exp);
    else pass_cnt++;
    tick();
    exp = mk(1, 0, 0, 1, 2);
    total_cnt++;
    if (st_c !== exp) $display("FAIL tmo_fire got %h exp %h", st_c, exp);
    else pass_cnt++;
    en = 1'b0; clr = 1'b1; tick();
    exp = mk(0, 0, 0, 0, 0);
    total_cnt++;
    if (st_c !== exp) $display("FAIL tmo_clr got %h exp %h", st_c, exp);
    else pass_cnt++;
    clr = 1'b0; en = 1'b1; tick();
  endtask

  task automatic test_timeout_race();
    ev = 4'b0001; tick();
    ev = 4'b0000;
    repeat (9) tick();
    ev = 4'b0010; tick();
    exp = mk(2, 1, 0, 0, 0);
    total_cnt++;
    if (st_c !== exp) $display("FAIL race_accept got %h exp %h", st_c, exp);
    else pass_cnt++;
    ev = 4'b0000; tick();
    total_cnt++;
    if (st_c !== exp) $display("FAIL race_rearm got %h exp %h", st_c, exp);
    else pass_cnt++;
    en = 1'b0; tick();
    en = 1'b1; tick();
  endtask

  task automatic test_simultaneous();
    ev = 4'b0011; tick();
    exp = mk(0, 0, 0, 1, 1);
    total_cnt++;
    if (st_a !== exp) $display("FAIL simul_strict got %h exp %h", st_a, exp);
    else pass_cnt++;
    exp = mk(1, 1, 0, 0, 0);
    total_cnt++;
    if (st_b !== exp) $display("FAIL simul_lenient got %h exp %h", st_b, exp);
    else pass_cnt++;
    ev = 4'b0000; en = 1'b0; clr = 1'b1; tick();
    clr = 1'b0; en = 1'b1; tick();
  endtask

  task automatic test_abort();
    ev = 4'b0001; tick();
    ev = 4'b0000; tick();
    ev = 4'b0010; tick();
    exp = mk(2, 1, 0, 0, 0);
    total_cnt++;
    if (st_a !== exp) $display("FAIL abort_s2 got %h exp %h", st_a, exp);
    else pass_cnt++;
    ev = 4'b0000; en = 1'b0; tick();
    exp = mk(0, 0, 0, 0, 0);
    total_cnt++;
    if (st_a !== exp) $display("FAIL abort_idle got %h exp %h", st_a, exp);
    else pass_cnt++;
    en = 1'b1; tick();
  endtask

  task automatic test_reset_mid();
    ev = 4'b0001; tick();
    ev = 4'b0000; tick();
    ev = 4'b0010; tick();
    ev = 4'b0000; tick();
    ev = 4'b0001;
    rstn = 1'b0;
    #2;
    exp = mk(0, 0, 0, 0, 0);
    total_cnt++;
    if (st_a !== exp) $display("FAIL rstmid_async got %h exp %h", st_a, exp);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (st_b !== exp) $display("FAIL rstmid_held got %h exp %h", st_b, exp);
    else pass_cnt++;
    rstn = 1'b1;
    tick();
    exp = mk(1, 1, 0, 0, 0);
    total_cnt++;
    if (st_a !== exp) $display("FAIL rstmid_rise got %h exp %h", st_a, exp);
    else pass_cnt++;
    ev = 4'b0000; tick();
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_order_strict();
    test_order_lenient();
    test_timeout();
    test_timeout_race();
    test_simultaneous();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
